tlul_sram_responder: RTL and testbench
======================================

// Module: tlul_sram_responder
// PURPOSE
//  TL-UL device (responder) endpoint: accepts A-channel requests from a host such as the Ibex
//  instruction/data ports and converts them to a fixed 1-cycle-latency SRAM req/we/addr interface.
//  Returns D-channel AccessAck/AccessAckData in order through a response FIFO.
//  Sits between the TL-UL crossbar device port and on-chip SRAM/ROM macros.
// PARAMETERS
//  SramAw       10  SRAM word-address width; byte range = 4*2^SramAw
//  Outstanding   2  max accepted-but-not-responded requests (response FIFO depth, >=1)
//  ReadOnly      0  1: Put* requests get d_error=1, SRAM untouched
// PORTS
//  clk_i                       in   1        clock
//  rst_i                       in   1        synchronous reset, active-high
//  tl_a_valid / tl_a_ready     in/out 1      A-channel handshake
//  tl_a_bits_opcode            in   3        0=PutFull 1=PutPartial 4=Get
//  tl_a_bits_size              in   TL_SZW   log2 bytes
//  tl_a_bits_source            in   TL_AIW   echoed on D
//  tl_a_bits_address           in   TL_AW    byte address
//  tl_a_bits_mask              in   TL_DBW   byte enables
//  tl_a_bits_data              in   TL_DW    write data
//  tl_a_bits_user_parity       in   8        per-byte parity (TLUL_RSP_PARITY_EN only)
//  tl_d_valid / tl_d_ready     out/in 1      D-channel handshake
//  tl_d_bits_opcode            out  3        0=AccessAck 1=AccessAckData
//  tl_d_bits_size/source       out  TL_SZW/TL_AIW  echoed from A
//  tl_d_bits_sink              out  TL_DIW   always 0
//  tl_d_bits_data              out  TL_DW    read data; 0 on error or write
//  tl_d_bits_error             out  1        request rejected
//  sram_req_o/sram_we_o        out  1        SRAM access strobe / write enable
//  sram_addr_o                 out  SramAw   word address = address[SramAw+1:2]
//  sram_wdata_o/sram_wmask_o   out  32/32    data, bit-expanded byte mask
//  sram_rdata_i                in   32       valid exactly 1 cycle after sram_req_o&&!sram_we_o
// BEHAVIOUR
//  Reset: tl_a_ready=0 during reset, 1 the cycle after; tl_d_valid=0; sram_req_o=0; FIFO empty,
//   pending stage empty; all data outputs 0.
//  Accept = tl_a_valid&&tl_a_ready. tl_a_ready = (fifo_count+pending) < Outstanding;
//   same-cycle D pop does NOT raise a_ready (no combinational d_ready->a_ready path).
//  Error check at accept (any -> error, no SRAM access): opcode not in {0,1,4}; size>2;
//   address not size-aligned; PutFull mask != required for size/offset; address[TL_AW-1:SramAw+2]!=0;
//   Put* when ReadOnly=1.
//  Valid, no error: sram_req_o=1 combinationally in the accept cycle; sram_we_o=1 for Put*.
//  Pending stage (1 entry) registers {opcode,size,source,error} on accept. Next cycle: push to
//   FIFO with data=sram_rdata_i for good Get, else 0. Response opcode: Get->1, Put*->0.
//  Latency: accept at cycle N -> tl_d_valid earliest N+2 (registered FIFO output).
//  D: tl_d_valid = !fifo_empty; pop on tl_d_valid&&tl_d_ready; fields stable while stalled.
//  Simultaneous push+pop on full FIFO: legal, count unchanged. In-order responses only.
//  Never drop: accept guarantees FIFO slot reserved (pending counted in capacity).
//  Reset mid-transaction: all in-flight requests discarded, no D response emitted afterwards.
// CONFIGURATION
//  `TLUL_RSP_PARITY_EN defined: for Put*, each enabled byte i must satisfy
//   ^a_data[8i+7:8i] ^ a_user_parity[i] == 1 (odd); violation -> error, no write.
//  Undefined: tl_a_bits_user_parity ignored; no parity logic instantiated.
// STRUCTURE
//  top_pkg: TL_AW/TL_DW/TL_AIW/TL_DIW/TL_SZW/TL_DBW.
//  tlul_pkg: tl_a_op_e {PutFullData=0,PutPartialData=1,Get=4}, tl_d_op_e {AccessAck=0,
//   AccessAckData=1}, rsp_entry_t packed struct {opcode,size,source,error,data}.
//  Sub-module tlul_rsp_fifo: sync FIFO of rsp_entry_t, depth Outstanding, full/empty/count.
// TESTING
//  Get addr 0x10, sram word4=0xDEADBEEF -> sram_addr_o=4 at accept; D opcode=1 data=0xDEADBEEF error=0.
//  PutPartial addr 0x8 mask 0b0110 data 0x11223344 -> sram_we_o=1 wmask=0x00FFFF00; D opcode=0.
//  Get size=2 addr 0x2 (misaligned) -> no sram_req_o; D opcode=1 error=1 data=0.
//  Outstanding=2, d_ready=0, 3 Gets -> 2 accepted, a_ready=0; d_ready=1 -> 2 in-order responses, 3rd accepted.
//  Source 0x5 then 0xA back-to-back with d_ready toggling -> D sources 0x5,0xA, fields stable while stalled.
//  rst_i asserted with 2 outstanding -> tl_d_valid=0 next cycle, no stale response after release.

Source files
------------

// File: rtl/tlul_sram_responder_pkg.sv
// Shared TL-UL widths, channel opcodes and the response entry format for the SRAM responder.
package tlul_sram_responder_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    tl_d_op_e            opcode;
    logic [TL_SZW-1:0]   size;
    logic [TL_AIW-1:0]   source;
    logic                error;
    logic [TL_DW-1:0]    data;
  } rsp_entry_t;

  // Byte mask a PutFull must carry for a given size and byte offset in the word.
  function automatic logic [TL_DBW-1:0] full_mask(input logic [TL_SZW-1:0] size,
                                                  input logic [1:0]        off);
    case (size)
      2'd0:    full_mask = 4'b0001 << off;
      2'd1:    full_mask = 4'b0011 << off;
      default: full_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// In-order response FIFO; head is read straight from storage registers.
module tlul_rsp_fifo
  import tlul_sram_responder_pkg::*;
#(
  parameter int Depth = 2,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  rsp_entry_t      wdata_i,
  input  logic            pop_i,
  output rsp_entry_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] cnt_o
);

  rsp_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    inc = (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= inc(wptr_q);
      if (do_pop)  rptr_q <= inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tlul_sram_responder.sv
// TL-UL device endpoint driving a 1-cycle-latency SRAM, responses returned in order.
// Optional feature: define TLUL_RSP_PARITY_EN to require odd per-byte parity on Put* data.
module tlul_sram_responder
  import tlul_sram_responder_pkg::*;
#(
  parameter int SramAw      = 10,
  parameter int Outstanding = 2,
  parameter bit ReadOnly    = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tl_a_valid,
  output logic              tl_a_ready,
  input  logic [2:0]        tl_a_bits_opcode,
  input  logic [TL_SZW-1:0] tl_a_bits_size,
  input  logic [TL_AIW-1:0] tl_a_bits_source,
  input  logic [TL_AW-1:0]  tl_a_bits_address,
  input  logic [TL_DBW-1:0] tl_a_bits_mask,
  input  logic [TL_DW-1:0]  tl_a_bits_data,
  input  logic [7:0]        tl_a_bits_user_parity,
  output logic              tl_d_valid,
  input  logic              tl_d_ready,
  output logic [2:0]        tl_d_bits_opcode,
  output logic [TL_SZW-1:0] tl_d_bits_size,
  output logic [TL_AIW-1:0] tl_d_bits_source,
  output logic [TL_DIW-1:0] tl_d_bits_sink,
  output logic [TL_DW-1:0]  tl_d_bits_data,
  output logic              tl_d_bits_error,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [31:0]       sram_wmask_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam int CntW = $clog2(Outstanding + 1);
  localparam logic [CntW:0] OutstN = Outstanding[CntW:0];

  logic            is_put, is_get, err, par_bad, accept;
  logic [31:0]     wmask_full;
  logic            pend_vld_q, pend_rd_q;
  rsp_entry_t      pend_q, pend_d, push_ent, head, d_ent;
  logic            fifo_empty, unused_fifo_full;
  logic [CntW-1:0] fifo_cnt;
  logic [CntW:0]   inflight;

  assign is_put = (tl_a_bits_opcode == PutFullData) || (tl_a_bits_opcode == PutPartialData);
  assign is_get = (tl_a_bits_opcode == Get);

`ifdef TLUL_RSP_PARITY_EN
  logic unused_par;
  assign unused_par = ^tl_a_bits_user_parity[7:TL_DBW];
  // Each enabled write byte plus its parity bit must have odd weight.
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < TL_DBW; i++) begin
      if (tl_a_bits_mask[i] && !((^tl_a_bits_data[8*i +: 8]) ^ tl_a_bits_user_parity[i]))
        par_bad = 1'b1;
    end
    par_bad = par_bad && is_put;
  end
`else
  logic unused_par;
  assign unused_par = ^tl_a_bits_user_parity;
  assign par_bad    = 1'b0;
`endif

  // Request legality; any failure turns the access into an error response with no SRAM strobe.
  always_comb begin
    err = 1'b0;
    if (!is_put && !is_get)                                      err = 1'b1;
    if (tl_a_bits_size > TL_SZW'(2))                             err = 1'b1;
    if (tl_a_bits_size == TL_SZW'(1) && tl_a_bits_address[0])    err = 1'b1;
    if (tl_a_bits_size == TL_SZW'(2) && tl_a_bits_address[1:0] != 2'b00) err = 1'b1;
    if (tl_a_bits_opcode == PutFullData &&
        tl_a_bits_mask != full_mask(tl_a_bits_size, tl_a_bits_address[1:0])) err = 1'b1;
    if ((tl_a_bits_address >> (SramAw + 2)) != '0)               err = 1'b1;
    if (ReadOnly && is_put)                                      err = 1'b1;
    if (par_bad)                                                 err = 1'b1;
  end

  // Byte enables widened to one bit per data bit.
  always_comb begin
    wmask_full = '0;
    for (int i = 0; i < TL_DBW; i++) wmask_full[8*i +: 8] = {8{tl_a_bits_mask[i]}};
  end

  // The pending stage counts against capacity, so an accepted request always has a FIFO slot.
  assign inflight   = {1'b0, fifo_cnt} + {{CntW{1'b0}}, pend_vld_q};
  assign tl_a_ready = !rst_i && (inflight < OutstN);
  assign accept     = tl_a_valid && tl_a_ready;

  assign sram_req_o   = accept && !err;
  assign sram_we_o    = sram_req_o && is_put;
  assign sram_addr_o  = sram_req_o ? tl_a_bits_address[SramAw+1:2] : '0;
  assign sram_wdata_o = sram_we_o ? tl_a_bits_data : '0;
  assign sram_wmask_o = sram_we_o ? wmask_full : '0;

  // Capture response metadata of the request accepted this cycle.
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d.opcode = is_get ? AccessAckData : AccessAck;
      pend_d.size   = tl_a_bits_size;
      pend_d.source = tl_a_bits_source;
      pend_d.error  = err;
      pend_d.data   = '0;
    end
  end

  // Pending stage register; waits one cycle for SRAM read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld_q <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= accept;
      pend_rd_q  <= sram_req_o && !sram_we_o;
      pend_q     <= pend_d;
    end
  end

  // Only a successful Get carries SRAM data; everything else responds with zero.
  always_comb begin
    push_ent      = pend_q;
    push_ent.data = pend_rd_q ? sram_rdata_i : '0;
  end

  tlul_rsp_fifo #(.Depth(Outstanding)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (pend_vld_q),
    .wdata_i (push_ent),
    .pop_i   (tl_d_valid && tl_d_ready),
    .rdata_o (head),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign tl_d_valid       = !fifo_empty;
  assign d_ent            = tl_d_valid ? head : '0;
  assign tl_d_bits_opcode = d_ent.opcode;
  assign tl_d_bits_size   = d_ent.size;
  assign tl_d_bits_source = d_ent.source;
  assign tl_d_bits_sink   = '0;
  assign tl_d_bits_data   = d_ent.data;
  assign tl_d_bits_error  = d_ent.error;

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Bench for tlul_sram_responder: directed cases then random traffic against a transaction-level model.
module tb_tlul_sram_responder;

  localparam int OUTST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_ready;
  logic [2:0]  a_op = '0;
  logic [1:0]  a_sz = '0;
  logic [7:0]  a_src = '0, a_par = '0;
  logic [31:0] a_addr = '0, a_data = '0;
  logic [3:0]  a_mask = '0;
  logic        d_valid, d_ready = 1'b0;
  logic [2:0]  d_op;
  logic [1:0]  d_sz;
  logic [7:0]  d_src;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_err;
  logic        req, we;
  logic [9:0]  saddr;
  logic [31:0] wdata, wmask;
  logic [31:0] rdata = '0;
  logic [31:0] env_mem [1024] = '{default: '0};

  tlul_sram_responder #(.SramAw(10), .Outstanding(OUTST), .ReadOnly(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .tl_a_valid(a_valid), .tl_a_ready(a_ready), .tl_a_bits_opcode(a_op),
    .tl_a_bits_size(a_sz), .tl_a_bits_source(a_src), .tl_a_bits_address(a_addr),
    .tl_a_bits_mask(a_mask), .tl_a_bits_data(a_data), .tl_a_bits_user_parity(a_par),
    .tl_d_valid(d_valid), .tl_d_ready(d_ready), .tl_d_bits_opcode(d_op),
    .tl_d_bits_size(d_sz), .tl_d_bits_source(d_src), .tl_d_bits_sink(d_sink),
    .tl_d_bits_data(d_data), .tl_d_bits_error(d_err),
    .sram_req_o(req), .sram_we_o(we), .sram_addr_o(saddr),
    .sram_wdata_o(wdata), .sram_wmask_o(wmask), .sram_rdata_i(rdata)
  );

  // SRAM macro stand-in: masked write, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (req) begin
      if (we) env_mem[saddr] <= (env_mem[saddr] & ~wmask) | (wdata & wmask);
      else    rdata <= env_mem[saddr];
    end
  end

  typedef struct {
    int          acc;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [1024];
  int          n_asrt = 0, n_fail = 0, cyc = 0;
  bit          accepted = 0, rst_prev = 0, stall_prev = 0, rand_rdy = 0;
  logic [45:0] d_prev = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [2:0] op, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data, input logic [7:0] par);
    int nb, need;
    if (op != 3'd0 && op != 3'd1 && op != 3'd4) return 1'b1;
    if (sz > 2'd2) return 1'b1;
    nb = 1 << sz;
    if (int'(addr % 32'(nb)) != 0) return 1'b1;
    need = ((1 << nb) - 1) << int'(addr % 32'd4);
    if (op == 3'd0 && int'(mask) != need) return 1'b1;
    if (addr >= 32'd4096) return 1'b1;
    if (op != 3'd4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef TLUL_RSP_PARITY_EN
        if (mask[i] && ($countones({data[8*i +: 8], par[i]}) % 2 == 0)) return 1'b1;
`else
        if (mask[i] && data[8*i] === 1'bx && par[i] === 1'bx) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  // One clock of observation: check outputs at the falling edge, update the model, step.
  task automatic cycle();
    bit          acc, pop, err, exp_dv;
    exp_t        e;
    logic [31:0] wm;
    logic [45:0] dcur;
    @(negedge clk);
    dcur = {d_op, d_sz, d_src, d_err, d_data};
    acc  = a_valid && a_ready;
    pop  = d_valid && d_ready;
    if (rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_sram_req", req, 0);
      if (rst_prev) begin
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_fields", dcur, 0);
      end
    end else begin
      exp_dv = 1'b0;
      if (q.size() > 0) exp_dv = (q[0].acc + 2 <= cyc);
      chk("a_ready", a_ready, q.size() < OUTST);
      chk("d_valid", d_valid, exp_dv);
      chk("d_sink", d_sink, 0);
      if (stall_prev) chk("d_stable", dcur, d_prev);
      if (pop && q.size() > 0) begin
        e = q.pop_front();
        chk("d_opcode", d_op, e.op);
        chk("d_size", d_sz, e.sz);
        chk("d_source", d_src, e.src);
        chk("d_error", d_err, e.err);
        chk("d_data", d_data, e.data);
      end
      if (acc) begin
        err = ref_err(a_op, a_sz, a_addr, a_mask, a_data, a_par);
        wm = '0;
        for (int i = 0; i < 4; i++) if (a_mask[i]) wm |= 32'hFF << (8 * i);
        chk("sram_req", req, !err);
        if (!err) begin
          chk("sram_we", we, a_op != 3'd4);
          chk("sram_addr", saddr, a_addr[11:2]);
          if (a_op != 3'd4) begin
            chk("sram_wdata", wdata, a_data);
            chk("sram_wmask", wmask, wm);
            ref_mem[a_addr[11:2]] = (ref_mem[a_addr[11:2]] & ~wm) | (a_data & wm);
          end
        end
        e.acc  = cyc;
        e.op   = (a_op == 3'd4) ? 3'd1 : 3'd0;
        e.sz   = a_sz;
        e.src  = a_src;
        e.err  = err;
        e.data = (!err && a_op == 3'd4) ? ref_mem[a_addr[11:2]] : 32'h0;
        q.push_back(e);
      end else begin
        chk("sram_idle", req, 0);
      end
    end
    accepted   = acc;
    stall_prev = !rst && d_valid && !d_ready;
    d_prev     = dcur;
    @(posedge clk);
    rst_prev = rst;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end
    #1;
    cyc++;
    if (rand_rdy) d_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_a(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    a_op = op; a_sz = sz; a_src = src; a_addr = addr; a_mask = mask; a_data = data;
    a_par = 8'($urandom);
    for (int i = 0; i < 4; i++) a_par[i] = ~(^data[8*i +: 8]);
    if ($urandom_range(0, 9) == 0) a_par[$urandom_range(0, 3)] ^= 1'b1;
    a_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    set_a(op, sz, src, addr, mask, data);
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", accepted, 1);
    a_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    d_ready  = 1'b1;
    for (int k = 0; k < 60 && q.size() > 0; k++) cycle();
    chk("drain_empty", q.size(), 0);
    cycle();
  endtask

  initial begin
    int          got;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [3:0]  mask;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // Reset state
    @(posedge clk); #1;
    rst_prev = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    d_ready = 1'b1;

    // Store 0xDEADBEEF at word 4, read it back through address 0x10
    send(3'd0, 2'd2, 8'h01, 32'h10, 4'hF, 32'hDEADBEEF);
    send(3'd4, 2'd2, 8'h02, 32'h10, 4'hF, 32'h0);
    drain();

    // PutPartial of the middle two bytes
    send(3'd1, 2'd2, 8'h03, 32'h8, 4'b0110, 32'h11223344);
    send(3'd4, 2'd2, 8'h04, 32'h8, 4'hF, 32'h0);
    // Misaligned word read
    send(3'd4, 2'd2, 8'h05, 32'h2, 4'hF, 32'h0);
    drain();

    // Capacity limit with D stalled
    d_ready = 1'b0;
    send(3'd4, 2'd2, 8'h10, 32'h0, 4'hF, 32'h0);
    send(3'd4, 2'd2, 8'h11, 32'h4, 4'hF, 32'h0);
    set_a(3'd4, 2'd2, 8'h12, 32'h8, 4'hF, 32'h0);
    got = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (accepted) got++;
    end
    chk("third_blocked", got, 0);
    d_ready = 1'b1;
    for (int k = 0; k < 10 && !accepted; k++) cycle();
    chk("third_accepted", accepted, 1);
    a_valid = 1'b0;
    drain();

    // Back-to-back sources with a toggling D ready
    rand_rdy = 1'b1;
    send(3'd4, 2'd2, 8'h05, 32'h10, 4'hF, 32'h0);
    send(3'd4, 2'd2, 8'h0A, 32'h8, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) cycle();
    drain();

    // Reset with two requests in flight
    d_ready = 1'b0;
    send(3'd4, 2'd2, 8'h20, 32'h0, 4'hF, 32'h0);
    send(3'd4, 2'd2, 8'h21, 32'h4, 4'hF, 32'h0);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    d_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();

    // Random traffic
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd4;
        3, 4, 5: op = 3'd0;
        6, 7, 8: op = 3'd1;
        default: op = 3'($urandom_range(0, 7));
      endcase
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      if (op == 3'd0 && $urandom_range(0, 7) != 0)
        mask = 4'(((1 << (1 << sz)) - 1) << int'(addr % 32'd4));
      else
        mask = 4'($urandom_range(0, 15));
      send(op, sz, 8'($urandom), addr, mask, $urandom);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
